// File: rtl/ddr4_avmm_tester_if.sv
// Avalon-MM command/response bundle between the DDR4 tester (master) and the EMIF user port (slave).
interface ddr4_avmm_tester_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 576
) ();
    logic              amm_ready;
    logic              amm_read;
    logic              amm_write;
    logic [ADDR_W-1:0] amm_address;
    logic [DATA_W-1:0] amm_writedata;
    logic [6:0]        amm_burstcount;
    logic [DATA_W-1:0] amm_readdata;
    logic              amm_readdatavalid;

    modport master (
        input  amm_ready, amm_readdata, amm_readdatavalid,
        output amm_read, amm_write, amm_address, amm_writedata, amm_burstcount
    );

    modport slave (
        output amm_ready, amm_readdata, amm_readdatavalid,
        input  amm_read, amm_write, amm_address, amm_writedata, amm_burstcount
    );
endinterface

// File: rtl/ddr4_avmm_tester.sv
// Write-then-read-back pattern tester for a DDR4 EMIF Avalon-MM port, with bounded outstanding reads.
// Optional macro DDR4_TESTER_ERR_INJECT_EN adds an inject_err input that flips bit 0 of accepted writes.
module ddr4_avmm_tester #(
    parameter int          ADDR_W    = 26,
    parameter int          DATA_W    = 576,
    parameter int          NUM_WORDS = 1024,
    parameter logic [31:0] SEED      = 32'hA5A5_0000,
    parameter int          MAX_OUTST = 32
) (
    input  logic                emif_usr_clk,
    input  logic                emif_usr_reset_n,
    input  logic                local_cal_success,
    input  logic                start,
`ifdef DDR4_TESTER_ERR_INJECT_EN
    input  logic                inject_err,
`endif
    ddr4_avmm_tester_if.master  amm,
    output logic                busy,
    output logic                pass,
    output logic                fail,
    output logic [15:0]         err_count,
    output logic [ADDR_W-1:0]   fail_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [7:0]        OUTST_LIM = 8'(MAX_OUTST);

    typedef enum logic [2:0] {IDLE, WAIT_CAL, WRITE, READ, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic [15:0]        err_q, err_d;
    logic [ADDR_W-1:0]  fail_addr_q, fail_addr_d;
    logic [7:0]         outst_q, outst_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]  addr_inc;
    logic               rd_acc, wr_acc, in_run;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        logic [31:0] word;
        word = 32'(a) ^ SEED;
        return {(DATA_W/32){word}};
    endfunction

    assign rd_acc   = read_q & amm.amm_ready;
    assign wr_acc   = write_q & amm.amm_ready;
    assign in_run   = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
    assign addr_inc = addr_q + 1'b1;

    always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
        if (!emif_usr_reset_n) begin
            state_q     <= IDLE;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            err_q       <= '0;
            fail_addr_q <= '0;
            outst_q     <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            read_q      <= read_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            outst_q     <= outst_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        read_d      = read_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        outst_d     = outst_q;
        rd_ptr_d    = rd_ptr_q;

        // Response checking; a strobe with nothing outstanding is itself an error.
        if (in_run) begin
            if (rd_acc)
                outst_d = outst_d + 8'd1;
            if (amm.amm_readdatavalid) begin
                if (outst_q != 8'd0)
                    outst_d = outst_d - 8'd1;
                rd_ptr_d = rd_ptr_q + 1'b1;
                if ((outst_q == 8'd0) || (amm.amm_readdata != pattern(rd_ptr_q))) begin
                    if (err_q != 16'hFFFF)
                        err_d = err_q + 16'd1;
                    if (err_q == 16'd0)
                        fail_addr_d = rd_ptr_q;
                end
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    err_d       = '0;
                    fail_addr_d = '0;
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    outst_d     = '0;
                    rd_ptr_d    = '0;
                    addr_d      = '0;
                    wdata_d     = pattern('0);
                    if (local_cal_success) begin
                        state_d = WRITE;
                        write_d = 1'b1;
                    end else begin
                        state_d = WAIT_CAL;
                    end
                end
            end
            WAIT_CAL: begin
                if (local_cal_success) begin
                    state_d = WRITE;
                    write_d = 1'b1;
                    addr_d  = '0;
                    wdata_d = pattern('0);
                end
            end
            WRITE: begin
                if (wr_acc) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = READ;
                        write_d = 1'b0;
                        addr_d  = '0;
                    end else begin
                        addr_d  = addr_inc;
                        wdata_d = pattern(addr_inc);
                    end
                end
            end
            READ: begin
                // A stalled read is held; otherwise issue only if room remains after this edge.
                if (rd_acc && (addr_q == LAST_ADDR)) begin
                    state_d = DRAIN;
                    read_d  = 1'b0;
                end else begin
                    if (rd_acc)
                        addr_d = addr_inc;
                    read_d = (read_q && !amm.amm_ready) || (outst_d < OUTST_LIM);
                end
            end
            DRAIN: begin
                if (outst_q == 8'd0) begin
                    state_d = DONE;
                    pass_d  = (err_d == 16'd0);
                    fail_d  = (err_d != 16'd0);
                end
            end
            default: state_d = IDLE;
        endcase

        if (in_run && !local_cal_success) begin
            state_d = DONE;
            read_d  = 1'b0;
            write_d = 1'b0;
            pass_d  = 1'b0;
            fail_d  = 1'b1;
            outst_d = '0;
        end
    end

    assign amm.amm_read       = read_q;
    assign amm.amm_write      = write_q;
    assign amm.amm_address    = addr_q;
    assign amm.amm_burstcount = 7'd1;
`ifdef DDR4_TESTER_ERR_INJECT_EN
    assign amm.amm_writedata  = {wdata_q[DATA_W-1:1], wdata_q[0] ^ (inject_err & write_q)};
`else
    assign amm.amm_writedata  = wdata_q;
`endif

    assign busy      = (state_q == WAIT_CAL) || in_run;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign err_count = err_q;
    assign fail_addr = fail_addr_q;

endmodule
